ysyx_23060221_wbu_pipe: RTL and testbench
=========================================

# ysyx_23060221_wbu_pipe

Parametrised, buffered write-back stage for the ysyx_23060221 core, sitting between the LSU and the register file and commit/trace port. It accepts retired instructions over a valid/ready handshake and selects the write-back value from ALU, load, CSR or link sources, applying load alignment and extension. Entries are buffered in a DEPTH-entry FIFO, so commit back-pressure does not stall the LSU immediately. Each instruction commits with a single register-file write, and a retired-instruction counter is maintained.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64
- DEPTH, 2: FIFO entries; power of two, ≥2
- CNT_W, 64: width of the retired-instruction counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  LSU presents an instruction
- in_ready  out  1  stage can accept an instruction
- in_pc  in  XLEN  PC of the instruction
- in_rd  in  5  destination register
- in_regw  in  1  instruction writes rd
- in_src  in  2  write-back source: 00 ALU, 01 LOAD, 10 CSR, 11 PC+4
- in_res  in  XLEN  ALU result
- in_ldata  in  XLEN  raw aligned memory word
- in_lsize  in  2  load size: 00 byte, 01 half, 10 word, 11 dword (XLEN=64 only)
- in_lunsigned  in  1  zero-extend the load
- in_addr_lo  in  $clog2(XLEN/8)  byte offset of the load address
- in_csr  in  XLEN  CSR read data
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- commit_valid  out  1  FIFO head is ready to commit
- commit_ready  in  1  commit consumer accepts the head
- commit_pc  out  XLEN  PC of the head entry
- minstret  out  CNT_W  count of retired instructions

## Operation
- Push occurs when in_valid & in_ready. The final write-back value is computed combinationally on the input side, then stored with pc, rd and wen. No raw source fields are stored.
- Stored wen is in_regw & (in_rd != 0). Writes to x0 are never issued.
- Source mux:
  - ALU selects in_res.
  - CSR selects in_csr.
  - PC+4 selects in_pc + 4, modulo 2^XLEN.
  - LOAD selects the extended load value.
- Load extension:
  - Shift in_ldata right by in_addr_lo×8, shifting in zero fill.
  - Take the low 8/16/32/64 bits according to in_lsize.
  - Sign-extend unless in_lunsigned is set.
  - Misalignment is not checked; the result is exactly this shift-then-extract.
  - in_lsize=11 with XLEN=32 is treated as word.
- Pop (fire) occurs when commit_valid & commit_ready.
  - In the fire cycle, rf_wen = the head's wen, and rf_waddr/rf_wdata come from the head.
  - rf_wen is 0 in every other cycle.
- minstret increments by 1 on each fire and wraps at 2^CNT_W.
- in_ready = !full. It is registered state only, with no combinational path from commit_ready.
- Push and pop in the same cycle are both performed, and occupancy is unchanged. When full, push is blocked even if a pop occurs.
- commit_valid = !empty.
- While empty, commit_pc, rf_waddr and rf_wdata are driven 0.

## Timing
- Reset:
  - FIFO is empty and pointers are 0.
  - minstret = 0, commit_valid = 0, rf_wen = 0, in_ready = 1.
  - All data outputs are 0.
- A reset asserted mid-operation discards all buffered entries with no rf write. It takes effect at the next edge.
- Latency: an entry pushed at edge N is visible at the head from cycle N+1. With commit_ready=1 it fires in cycle N+1, and rf is written at edge N+2.
- Throughput is 1 instruction per cycle sustained when commit_ready=1.
- Ordering is strictly FIFO.
- Pointers are $clog2(DEPTH) bits plus a wrap bit. Full means the pointers are equal with the wrap bits differing.

## Structure
- Package ysyx_23060221_wbu_pkg holds:
  - the wb_src_e and ld_size_e enums
  - the entry struct {pc, rd, wen, wdata}
  - a load-extend function parametrised by XLEN
- One sub-module, ysyx_23060221_wb_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH, reporting full/empty.

## Test plan
- Load byte, signed: in_ldata=0x80FF_0000, addr_lo=3, lsize=00 -> rf_wdata=0xFFFF_FF80. With in_lunsigned=1 -> 0x0000_0080.
- Link: src=11, pc=0x8000_0FFC, rd=1 -> rf_wen=1, rf_waddr=1, rf_wdata=0x8000_1000, one cycle after accept.
- x0 write: in_regw=1, rd=0 -> commit fires, rf_wen stays 0, minstret increments.
- Back-pressure: commit_ready=0, push 3 entries with DEPTH=2 -> in_ready=0 after the 2nd push, 3rd held. Then commit_ready=1 -> commits in order with one-per-cycle rf writes.
- Simultaneous push/pop at occupancy 1 over 10 cycles -> occupancy stays 1, minstret=10.
- Reset with 2 entries buffered -> next cycle commit_valid=0, minstret=0, in_ready=1, and no rf_wen pulse.

Source files
------------

// File: rtl/ysyx_23060221_wbu_pkg.sv
// ysyx_23060221_wbu_pkg: shared types and load-extension helper for the write-back stage
package ysyx_23060221_wbu_pkg;
  localparam int XLEN_MAX = 64;
  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_CSR, WB_LINK} wb_src_e;
  typedef enum logic [1:0] {LD_B, LD_H, LD_W, LD_D} ld_size_e;
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rd;
    logic                wen;
    logic [XLEN_MAX-1:0] wdata;
  } entry_t;
  // Works at 64 bits; with xlen=32 a dword request collapses to a word and callers truncate.
  function automatic logic [XLEN_MAX-1:0] load_ext(input logic [XLEN_MAX-1:0] data, input logic [2:0] off,
                                                   input ld_size_e size, input logic uns, input int xlen);
    logic [XLEN_MAX-1:0] sh;
    sh = data >> {off, 3'b000};
    return size == LD_B ? {{56{!uns && sh[7]}}, sh[7:0]} :
           size == LD_H ? {{48{!uns && sh[15]}}, sh[15:0]} :
           (size == LD_W || xlen == 32) ? {{32{!uns && sh[31]}}, sh[31:0]} : sh;
  endfunction
endpackage

// File: rtl/ysyx_23060221_wb_fifo.sv
// ysyx_23060221_wb_fifo: generic synchronous FIFO with wrap-bit pointers
module ysyx_23060221_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
    if (do_push && !rst) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ysyx_23060221_wbu_pipe.sv
// ysyx_23060221_wbu_pipe: buffered write-back stage selecting and committing the final rd value
module ysyx_23060221_wbu_pipe
  import ysyx_23060221_wbu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64,
  localparam int OW = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rd,
  input  logic             in_regw,
  input  logic [1:0]       in_src,
  input  logic [XLEN-1:0]  in_res,
  input  logic [XLEN-1:0]  in_ldata,
  input  logic [1:0]       in_lsize,
  input  logic             in_lunsigned,
  input  logic [OW-1:0]    in_addr_lo,
  input  logic [XLEN-1:0]  in_csr,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [XLEN-1:0]  commit_pc,
  output logic [CNT_W-1:0] minstret
);
  wb_src_e src;
  logic [XLEN-1:0] wd;
  entry_t in_e, head;
  logic full, empty, fire;
  assign src = wb_src_e'(in_src);
  always_comb begin
    wd = src == WB_ALU ? in_res :
         src == WB_CSR ? in_csr :
         src == WB_LINK ? in_pc + XLEN'(4) :
         XLEN'(load_ext(XLEN_MAX'(in_ldata), 3'(in_addr_lo), ld_size_e'(in_lsize), in_lunsigned, XLEN));
    in_e = '{pc: XLEN_MAX'(in_pc), rd: in_rd, wen: in_regw && in_rd != 5'd0, wdata: XLEN_MAX'(wd)};
  end
  ysyx_23060221_wb_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .pop(commit_ready),
    .wdata(in_e),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign in_ready = !full;
  assign commit_valid = !empty;
  assign fire = commit_valid && commit_ready;
  assign rf_wen = fire && head.wen;
  assign rf_waddr = empty ? 5'd0 : head.rd;
  assign rf_wdata = empty ? '0 : XLEN'(head.wdata);
  assign commit_pc = empty ? '0 : XLEN'(head.pc);
  always_ff @(posedge clk) begin
    if (rst) minstret <= '0;
    else if (fire) minstret <= minstret + CNT_W'(1);
  end
endmodule

// File: tb/tb_ysyx_23060221_wbu_pipe.sv
// tb_ysyx_23060221_wbu_pipe: directed and random checks against a queue-based model
module tb_ysyx_23060221_wbu_pipe;
  localparam int XLEN = 32, DEPTH = 2, CNT_W = 64;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_regw = 0, in_lunsigned = 0;
  logic [31:0] in_pc = 0, in_res = 0, in_ldata = 0, in_csr = 0;
  logic [4:0] in_rd = 0;
  logic [1:0] in_src = 0, in_lsize = 0, in_addr_lo = 0;
  logic rf_wen, commit_valid, commit_ready = 0;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, commit_pc;
  logic [63:0] minstret;
  typedef struct {logic [31:0] pc; logic [4:0] rd; logic wen; logic [31:0] wd;} exp_t;
  exp_t q[$];
  logic [63:0] cnt = 0;
  bit armed = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ysyx_23060221_wbu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_regw(in_regw), .in_src(in_src), .in_res(in_res), .in_ldata(in_ldata), .in_lsize(in_lsize),
    .in_lunsigned(in_lunsigned), .in_addr_lo(in_addr_lo), .in_csr(in_csr), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .minstret(minstret)
  );

  function automatic logic [31:0] ref_wd(input logic [1:0] src, input logic [31:0] pc, res, ldata, csr,
                                         input logic [1:0] lsize, off, input logic uns);
    logic [63:0] v, m;
    int w;
    w = lsize == 2'd0 ? 8 : lsize == 2'd1 ? 16 : 32;
    m = (64'd1 << w) - 64'd1;
    v = {32'd0, ldata >> (8 * off)} & m;
    if (!uns && v[w-1]) v = v | ~m;
    return src == 2'd0 ? res : src == 2'd2 ? csr : src == 2'd3 ? pc + 32'd4 : v[31:0];
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cnt = 0;
      armed = 1;
    end else if (armed) begin
      bit pop, push;
      pop = commit_ready && q.size() > 0;
      push = in_valid && q.size() < DEPTH;
      if (pop) begin
        void'(q.pop_front());
        cnt++;
      end
      if (push) q.push_back('{pc: in_pc, rd: in_rd, wen: in_regw && in_rd != 0,
                              wd: ref_wd(in_src, in_pc, in_res, in_ldata, in_csr, in_lsize, in_addr_lo, in_lunsigned)});
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("commit_valid", commit_valid, q.size() > 0);
      chk("minstret", minstret, cnt);
      if (q.size() > 0) begin
        chk("commit_pc", commit_pc, q[0].pc);
        chk("rf_waddr", rf_waddr, q[0].rd);
        chk("rf_wdata", rf_wdata, q[0].wd);
        chk("rf_wen", rf_wen, commit_ready && q[0].wen);
      end else begin
        chk("idle_zero", {commit_pc, rf_wdata}, 64'd0);
        chk("idle_waddr_wen", {rf_waddr, rf_wen}, 6'd0);
      end
    end
  end

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rd, input logic regw, input logic [1:0] src,
                        input logic [31:0] res, ldata, input logic [1:0] lsize, input logic uns,
                        input logic [1:0] off, input logic [31:0] csr);
    in_pc = pc; in_rd = rd; in_regw = regw; in_src = src; in_res = res;
    in_ldata = ldata; in_lsize = lsize; in_lunsigned = uns; in_addr_lo = off; in_csr = csr;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [4:0] rd, input logic regw, input logic [1:0] src,
                          input logic [31:0] res, ldata, input logic [1:0] lsize, input logic uns,
                          input logic [1:0] off, input logic [31:0] csr);
    @(posedge clk); #1;
    set_in(pc, rd, regw, src, res, ldata, lsize, uns, off, csr);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_minstret", minstret, 0);
    chk("rst_rf_wen", rf_wen, 0);
    @(posedge clk); #1 commit_ready = 1;
    push_one(32'h100, 5'd5, 1, 2'b01, 0, 32'h80FF_0000, 2'b00, 0, 2'd3, 0);
    chk("lb_wen", rf_wen, 1);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    push_one(32'h104, 5'd6, 1, 2'b01, 0, 32'h80FF_0000, 2'b00, 1, 2'd3, 0);
    chk("lbu_wdata", rf_wdata, 32'h0000_0080);
    push_one(32'h8000_0FFC, 5'd1, 1, 2'b11, 0, 0, 2'b00, 0, 2'd0, 0);
    chk("link_wen", rf_wen, 1);
    chk("link_waddr", rf_waddr, 5'd1);
    chk("link_wdata", rf_wdata, 32'h8000_1000);
    push_one(32'h200, 5'd0, 1, 2'b00, 32'h1234, 0, 2'b00, 0, 2'd0, 0);
    chk("x0_valid", commit_valid, 1);
    chk("x0_wen", rf_wen, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("x0_minstret", minstret, 4);
    // back-pressure: A, B fill the FIFO; C must wait until a slot frees
    @(posedge clk); #1 commit_ready = 0;
    set_in(32'h300, 5'd2, 1, 2'b00, 32'hA, 0, 0, 0, 0, 0); in_valid = 1;
    @(posedge clk); #1 set_in(32'h304, 5'd3, 1, 2'b00, 32'hB, 0, 0, 0, 0, 0);
    @(posedge clk); #1 set_in(32'h308, 5'd4, 1, 2'b10, 0, 0, 0, 0, 0, 32'hC);
    @(negedge clk);
    chk("bp_full", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_head", rf_waddr, 5'd2);
    @(posedge clk); #1 commit_ready = 1;
    @(negedge clk);
    chk("bp_a", {rf_wen, rf_wdata}, {1'b1, 32'hA});
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_b", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd3, 32'hB});
    chk("bp_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("bp_c", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd4, 32'hC});
    // steady push+pop at occupancy 1
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; commit_ready = 0;
    push_one(32'h400, 5'd7, 1, 2'b00, 32'h77, 0, 0, 0, 0, 0);
    @(posedge clk); #1 commit_ready = 1; in_valid = 1;
    repeat (10) @(posedge clk);
    #1 in_valid = 0; commit_ready = 0;
    @(negedge clk);
    chk("pp_minstret", minstret, 10);
    chk("pp_valid", commit_valid, 1);
    // reset with two entries buffered
    push_one(32'h500, 5'd8, 1, 2'b00, 32'h88, 0, 0, 0, 0, 0);
    chk("pre_rst_full", in_ready, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_rst", {commit_valid, in_ready, rf_wen}, 3'b010);
    chk("mid_rst_minstret", minstret, 0);
    repeat (3000) begin
      @(posedge clk); #1;
      set_in($urandom, 5'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
             2'($urandom), 1'($urandom), 2'($urandom), $urandom);
      in_valid = 1'($urandom);
      commit_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
    end
    @(posedge clk); #1 in_valid = 0; rst = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
